tomasulo_rob_param: RTL and testbench

- Parametrised reorder buffer for the Tomasulo core. Successor to the fixed 8-entry ROB array driven by head_p/tail_p.
- Allocates entries in program order at dispatch and captures results broadcast on the common data bus (CDB).
- Retires one entry per cycle in order to the register bank.
- Flushes all younger entries when a mispredicted branch retires. Provides a combinational operand-lookup port for the issue stage.

---
 rtl/tomasulo_rob_param.sv | 100 ++++++++++
 tb/tb_tomasulo_rob_param.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_rob_param.sv
// tomasulo_rob_param: parametrised reorder buffer with in-order retire, CDB capture,
// mispredict flush and a combinational operand-lookup port.
module tomasulo_rob_param #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int TAG_W  = 3
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [REG_AW-1:0] disp_dest,
  input  logic              disp_is_branch,
  output logic              disp_ready,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              cdb_mispredict,
  input  logic [TAG_W-1:0]  src_tag,
  output logic              src_ready,
  output logic [DATA_W-1:0] src_value,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_AW-1:0] commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic              commit_we,
  output logic              flush,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);
  logic [DEPTH-1:0]  valid, done, is_br, mis;
  logic [REG_AW-1:0] dest [DEPTH];
  logic [DATA_W-1:0] value [DEPTH];
  logic [TAG_W-1:0]  head, tail;
  logic              head_retire, head_flush, dispatch, cdb_wr;
  assign head_retire = valid[head] & done[head];
  assign head_flush  = head_retire & is_br[head] & mis[head];
  assign full        = count == (TAG_W+1)'(DEPTH);
  assign empty       = count == '0;
  assign disp_ready  = !full & !head_flush;
  assign disp_tag    = tail;
  assign dispatch    = disp_valid & disp_ready;
  // a mispredict retire discards everything younger, including this cycle's broadcast
  assign cdb_wr      = cdb_valid & valid[cdb_tag] & !done[cdb_tag] & !head_flush;
  assign src_ready   = valid[src_tag] & done[src_tag];
  assign src_value   = value[src_tag];
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      valid        <= '0;
      done         <= '0;
      is_br        <= '0;
      mis          <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_dest  <= '0;
      commit_value <= '0;
      commit_we    <= 1'b0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= head_retire;
      commit_we    <= head_retire & !is_br[head];
      flush        <= head_flush;
      if (head_retire) begin
        commit_tag   <= head;
        commit_dest  <= dest[head];
        commit_value <= value[head];
        valid[head]  <= 1'b0;
        head         <= head + TAG_W'(1);
      end
      if (head_flush) begin
        valid <= '0;
        done  <= '0;
        tail  <= head + TAG_W'(1);
        count <= '0;
      end else begin
        if (cdb_wr) begin
          done[cdb_tag] <= 1'b1;
          mis[cdb_tag]  <= cdb_mispredict & is_br[cdb_tag];
        end
        if (dispatch) begin
          valid[tail] <= 1'b1;
          done[tail]  <= 1'b0;
          is_br[tail] <= disp_is_branch;
          mis[tail]   <= 1'b0;
          tail        <= tail + TAG_W'(1);
        end
        count <= count + (TAG_W+1)'(dispatch) - (TAG_W+1)'(head_retire);
      end
    end
  end
  always_ff @(posedge clk1) begin
    if (dispatch) dest[tail] <= disp_dest;
    if (cdb_wr) value[cdb_tag] <= cdb_value;
  end
endmodule

// File: tb/tb_tomasulo_rob_param.sv
// tb_tomasulo_rob_param: scoreboard bench driving an 8-entry and a 16-entry ROB with shared stimulus.
module tb_tomasulo_rob_param;
  logic clk1 = 0, rst = 1;
  logic disp_valid = 0, disp_is_branch = 0, cdb_valid = 0, cdb_mispredict = 0;
  logic [3:0] disp_dest = 0, cdb_tag = 0, src_tag = 0;
  logic [15:0] cdb_value = 0;
  logic r8, sr8, cv8, cwe8, f8, e8, fu8;
  logic [2:0] t8, ct8;
  logic [3:0] cd8, cnt8;
  logic [15:0] sv8, cval8;
  logic r16, sr16, cv16, cwe16, f16, e16, fu16;
  logic [3:0] t16, ct16, cd16;
  logic [4:0] cnt16;
  logic [15:0] sv16, cval16;
  logic o_ready, o_sr, o_cv, o_cwe, o_f, o_empty, o_full;
  logic [3:0] o_dtag, o_ct, o_cd;
  logic [4:0] o_cnt;
  logic [15:0] o_sv, o_cval;
  bit d16 = 0;
  int errors = 0, checks = 0, m_tail = 0, mask = 7;
  typedef struct {logic [3:0] tag; logic [3:0] dest; bit br;} ent_t;
  ent_t q[$];
  ent_t mon_e;
  bit mon_f;
  logic [15:0] exp_val [16];
  bit exp_done [16];
  bit exp_mis [16];

  tomasulo_rob_param #(.DEPTH(8), .DATA_W(16), .REG_AW(4), .TAG_W(3)) dut8 (
    .clk1(clk1), .rst(rst), .disp_valid(disp_valid), .disp_dest(disp_dest),
    .disp_is_branch(disp_is_branch), .disp_ready(r8), .disp_tag(t8), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag[2:0]), .cdb_value(cdb_value), .cdb_mispredict(cdb_mispredict),
    .src_tag(src_tag[2:0]), .src_ready(sr8), .src_value(sv8), .commit_valid(cv8),
    .commit_tag(ct8), .commit_dest(cd8), .commit_value(cval8), .commit_we(cwe8),
    .flush(f8), .count(cnt8), .empty(e8), .full(fu8));
  tomasulo_rob_param #(.DEPTH(16), .DATA_W(16), .REG_AW(4), .TAG_W(4)) dut16 (
    .clk1(clk1), .rst(rst), .disp_valid(disp_valid), .disp_dest(disp_dest),
    .disp_is_branch(disp_is_branch), .disp_ready(r16), .disp_tag(t16), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_mispredict(cdb_mispredict),
    .src_tag(src_tag), .src_ready(sr16), .src_value(sv16), .commit_valid(cv16),
    .commit_tag(ct16), .commit_dest(cd16), .commit_value(cval16), .commit_we(cwe16),
    .flush(f16), .count(cnt16), .empty(e16), .full(fu16));

  always #5 clk1 = ~clk1;

  always_comb begin
    o_ready = d16 ? r16 : r8;
    o_dtag  = d16 ? t16 : {1'b0, t8};
    o_sr    = d16 ? sr16 : sr8;
    o_sv    = d16 ? sv16 : sv8;
    o_cv    = d16 ? cv16 : cv8;
    o_ct    = d16 ? ct16 : {1'b0, ct8};
    o_cd    = d16 ? cd16 : cd8;
    o_cval  = d16 ? cval16 : cval8;
    o_cwe   = d16 ? cwe16 : cwe8;
    o_f     = d16 ? f16 : f8;
    o_cnt   = d16 ? cnt16 : {1'b0, cnt8};
    o_empty = d16 ? e16 : e8;
    o_full  = d16 ? fu16 : fu8;
  end

  // retire monitor: every commit pops the oldest expected entry
  always @(negedge clk1) begin
    if (!rst && o_cv) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got tag %0d, required no commit", o_ct);
      end else begin
        mon_e = q.pop_front();
        mon_f = mon_e.br && exp_mis[mon_e.tag];
        if ({o_ct, o_cd, o_cval, o_cwe, o_f} !== {mon_e.tag, mon_e.dest, exp_val[mon_e.tag], !mon_e.br, mon_f}) begin
          errors++;
          $display("FAIL commit: got tag=%0d dest=%0d val=%h we=%b flush=%b, required tag=%0d dest=%0d val=%h we=%b flush=%b",
                   o_ct, o_cd, o_cval, o_cwe, o_f, mon_e.tag, mon_e.dest, exp_val[mon_e.tag], !mon_e.br, mon_f);
        end
        if (mon_f) begin
          q.delete();
          m_tail = (int'(mon_e.tag) + 1) & mask;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic reset_all();
    rst = 1;
    disp_valid = 0; cdb_valid = 0; cdb_mispredict = 0;
    q.delete();
    m_tail = 0;
    mask = d16 ? 15 : 7;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic cyc(input bit dv, input logic [3:0] dd, input bit br, input bit acc,
                     input bit cv, input logic [3:0] ct, input logic [15:0] cval, input bit mp);
    disp_valid = dv; disp_dest = dd; disp_is_branch = br;
    cdb_valid = cv; cdb_tag = ct; cdb_value = cval; cdb_mispredict = mp;
    #1;
    if (cv)
      foreach (q[i])
        if (q[i].tag == ct && !exp_done[ct]) begin
          exp_done[ct] = 1;
          exp_val[ct] = cval;
          exp_mis[ct] = mp && q[i].br;
        end
    if (dv) begin
      checks++;
      if (o_ready !== acc) begin
        errors++;
        $display("FAIL disp_ready: got %b required %b", o_ready, acc);
      end
      if (acc) begin
        checks++;
        if (o_dtag !== 4'(m_tail)) begin
          errors++;
          $display("FAIL disp_tag: got %0d required %0d", o_dtag, m_tail);
        end
        q.push_back('{4'(m_tail), dd, br});
        exp_done[m_tail] = 0;
        exp_mis[m_tail] = 0;
        m_tail = (m_tail + 1) & mask;
      end
    end
    tick();
    disp_valid = 0; cdb_valid = 0; cdb_mispredict = 0;
  endtask

  task automatic wait_drain(input int n);
    int k = 0;
    while (q.size() != n && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (q.size() != n) begin
      errors++;
      $display("FAIL drain: got %0d pending commits, required %0d", q.size(), n);
    end
  endtask

  task automatic check_count(input logic [4:0] c);
    checks++;
    if (o_cnt !== c || o_empty !== (c == 0)) begin
      errors++;
      $display("FAIL count: got %0d empty=%b, required %0d", o_cnt, o_empty, c);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    #2;
    checks++;
    if ({o_cnt, o_empty, o_full, o_cv, o_cwe, o_f, o_ready, o_dtag} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset: got cnt=%0d empty=%b full=%b cv=%b we=%b flush=%b rdy=%b tag=%0d, required 0 1 0 0 0 0 1 0",
               o_cnt, o_empty, o_full, o_cv, o_cwe, o_f, o_ready, o_dtag);
    end
    reset_all();
  endtask

  task automatic test_basic();
    reset_all();
    cyc(1, 3, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 0, 1, 0, 0, 0, 0);
    cyc(1, 7, 0, 1, 0, 0, 0, 0);
    check_count(3);
    cyc(0, 0, 0, 0, 1, 1, 16'h0011, 0);
    cyc(0, 0, 0, 0, 1, 0, 16'h0022, 0);
    wait_drain(1);
    check_count(1);
    repeat (4) tick();
    src_tag = 2;
    #1;
    checks++;
    if (q.size() != 1 || o_sr !== 1'b0) begin
      errors++;
      $display("FAIL hold_tag2: got pending=%0d src_ready=%b, required 1 0", q.size(), o_sr);
    end
    cyc(0, 0, 0, 0, 1, 2, 16'h0033, 0);
    wait_drain(0);
    check_count(0);
  endtask

  task automatic test_full();
    ent_t snap[$];
    reset_all();
    for (int i = 0; i < 8; i++) cyc(1, 4'(i), 0, 1, 0, 0, 0, 0);
    checks++;
    if (o_full !== 1'b1 || o_ready !== 1'b0 || o_cnt !== 5'd8) begin
      errors++;
      $display("FAIL full: got full=%b ready=%b cnt=%0d, required 1 0 8", o_full, o_ready, o_cnt);
    end
    cyc(1, 9, 0, 0, 0, 0, 0, 0);
    check_count(8);
    cyc(0, 0, 0, 0, 1, 0, 16'h00A0, 0);
    cyc(1, 10, 0, 0, 1, 1, 16'h00A1, 0);
    check_count(7);
    cyc(1, 10, 0, 1, 0, 0, 0, 0);
    check_count(7);
    cyc(1, 11, 0, 1, 0, 0, 0, 0);
    check_count(8);
    snap = q;
    foreach (snap[i]) cyc(0, 0, 0, 0, 1, snap[i].tag, 16'h00B0 + 16'(snap[i].tag), 0);
    wait_drain(0);
    check_count(0);
  endtask

  task automatic test_flush();
    reset_all();
    cyc(1, 1, 0, 1, 0, 0, 0, 0);
    cyc(1, 2, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 4, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 0, 1, 0, 0, 0, 0);
    cyc(1, 6, 0, 1, 1, 3, 16'h0030, 0);
    cyc(0, 0, 0, 0, 1, 0, 16'h0010, 0);
    cyc(0, 0, 0, 0, 1, 1, 16'h0020, 0);
    cyc(0, 0, 0, 0, 1, 2, 16'h0000, 1);
    wait_drain(0);
    check_count(0);
    src_tag = 3;
    #1;
    checks++;
    if (o_dtag !== 4'd3 || o_sr !== 1'b0) begin
      errors++;
      $display("FAIL after_flush: got disp_tag=%0d src_ready=%b, required 3 0", o_dtag, o_sr);
    end
    cyc(0, 0, 0, 0, 1, 4, 16'h0044, 0);
    src_tag = 4;
    #1;
    checks++;
    if (o_sr !== 1'b0 || o_cnt !== 5'd0) begin
      errors++;
      $display("FAIL cdb_after_flush: got src_ready=%b cnt=%0d, required 0 0", o_sr, o_cnt);
    end
    cyc(1, 9, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3, 16'h0099, 0);
    wait_drain(0);
  endtask

  task automatic test_ignore();
    reset_all();
    cyc(0, 0, 0, 0, 1, 5, 16'h0077, 0);
    src_tag = 5;
    #1;
    checks++;
    if (o_sr !== 1'b0 || o_cnt !== 5'd0) begin
      errors++;
      $display("FAIL cdb_empty_slot: got src_ready=%b cnt=%0d, required 0 0", o_sr, o_cnt);
    end
    cyc(1, 4, 0, 1, 0, 0, 0, 0);
    cyc(1, 6, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 16'h0055, 0);
    cyc(0, 0, 0, 0, 1, 1, 16'h0099, 0);
    src_tag = 1;
    #1;
    checks++;
    if (o_sr !== 1'b1 || o_sv !== 16'h0055) begin
      errors++;
      $display("FAIL lookup_done: got ready=%b value=%h, required 1 0055", o_sr, o_sv);
    end
    src_tag = 0;
    #1;
    checks++;
    if (o_sr !== 1'b0) begin
      errors++;
      $display("FAIL lookup_not_done: got ready=%b required 0", o_sr);
    end
    cyc(0, 0, 0, 0, 1, 0, 16'h0044, 0);
    wait_drain(0);
    check_count(0);
  endtask

  task automatic test_reset_mid();
    reset_all();
    for (int i = 0; i < 6; i++) cyc(1, 4'(i + 1), 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 16'h00AB, 0);
    tick();
    checks++;
    if (o_cv !== 1'b1 || o_cnt !== 5'd5) begin
      errors++;
      $display("FAIL pre_reset: got cv=%b cnt=%0d, required 1 5", o_cv, o_cnt);
    end
    #1;
    rst = 1;
    #1;
    checks++;
    if ({o_cv, o_cwe, o_f, o_cnt, o_empty, o_full, o_dtag, o_ct, o_cval} !== {1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 4'd0, 16'd0}) begin
      errors++;
      $display("FAIL async_reset: got cv=%b we=%b flush=%b cnt=%0d empty=%b full=%b tag=%0d ctag=%0d cval=%h, required all clear",
               o_cv, o_cwe, o_f, o_cnt, o_empty, o_full, o_dtag, o_ct, o_cval);
    end
    q.delete();
    m_tail = 0;
    tick();
    rst = 0;
    tick();
    cyc(1, 2, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 16'h00CD, 0);
    wait_drain(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_ignore();
    test_reset_mid();
    d16 = 1;
    test_reset();
    test_basic();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
